// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the FIR coefficient loader: FSM states, control-word
// field positions and status-word bit positions.
package fir_coeff_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WR_EVEN   = 2'd1,
      WR_ODD    = 2'd2,
      WAIT_SYNC = 2'd3
   } fsm_state_e;

   localparam int TOGGLE_BIT = 31;
   localparam int COMMIT_BIT = 30;
   localparam int PAIR_LSB   = 0;
   localparam int PAIR_W     = 8;

   localparam int ST_BUSY     = 31;
   localparam int ST_OVERRUN  = 30;
   localparam int ST_ADDR_ERR = 29;
   localparam int ST_TIMEOUT  = 28;
   localparam int ST_BANK     = 27;
   localparam int ST_CNT_LSB  = 0;
   localparam int ST_CNT_W    = 16;

endpackage

// File: rtl/fir_coeff_sync_timer.sv
// Frame-sync watchdog: counts while start_i is high, zeroed by clear_i.
// expired_o flags the SYNC_TIMEOUT-th counting cycle (count == SYNC_TIMEOUT-1).
module fir_coeff_sync_timer #(
   parameter int SYNC_TIMEOUT = 65536
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic start_i,
   output logic expired_o
);

   localparam int CNT_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SYNC_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (start_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = start_i && (cnt_q == LAST);

endmodule

// File: rtl/fir_coeff_load_ctrl.sv
// Writes PPC coefficient pairs into the FIR shadow bank and swaps banks on the next frame sync.
// First RAM write lands 2 cycles after the control word toggles; toggles seen while busy set overrun.
module fir_coeff_load_ctrl
   import fir_coeff_pkg::*;
#(
   parameter int NPAIRS       = 16,
   parameter int COEF_W       = 16,
   parameter int ADDR_W       = 5,
   parameter int SYNC_TIMEOUT = 65536
) (
   input  logic              OPB_Clk,
   input  logic              OPB_Rst,
   input  logic [31:0]       coef_data_reg,
   input  logic [31:0]       coef_ctrl_reg,
   input  logic              sync_in,
   output logic              coef_we,
   output logic [ADDR_W-1:0] coef_addr,
   output logic [COEF_W-1:0] coef_wdata,
   output logic              bank_swap,
   output logic              active_bank,
   output logic              busy,
   output logic [31:0]       status
);

   logic [31:0]       data_q;
   logic [31:0]       ctrl_q;
   logic              sync_q;
   fsm_state_e        state_q;
   logic              last_toggle_q;
   logic [PAIR_W-1:0] pair_q;
   logic              commit_q;
   logic [COEF_W-1:0] odd_q;
   logic [15:0]       cmd_count_q;
   logic              overrun_q;
   logic              addr_err_q;
   logic              timeout_q;
   logic              active_bank_q;
   logic              bank_swap_q;
   logic              coef_we_q;
   logic [ADDR_W-1:0] coef_addr_q;
   logic [COEF_W-1:0] coef_wdata_q;

   logic              new_cmd;
   logic [PAIR_W-1:0] new_pair;
   logic              pair_bad;
   logic              tmr_expired;
   logic              unused_ctrl_bits;

   assign new_cmd          = ctrl_q[TOGGLE_BIT] != last_toggle_q;
   assign new_pair         = ctrl_q[PAIR_LSB +: PAIR_W];
   assign pair_bad         = int'(new_pair) >= NPAIRS;
   assign unused_ctrl_bits = ^ctrl_q[29:8];

   // Timer only runs in WAIT_SYNC and restarts from zero on every entry.
   fir_coeff_sync_timer #(
      .SYNC_TIMEOUT (SYNC_TIMEOUT)
   ) u_sync_timer (
      .clk_i     (OPB_Clk),
      .rst_i     (OPB_Rst),
      .clear_i   (state_q != WAIT_SYNC),
      .start_i   (state_q == WAIT_SYNC),
      .expired_o (tmr_expired)
   );

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         data_q        <= '0;
         ctrl_q        <= '0;
         sync_q        <= 1'b0;
         state_q       <= IDLE;
         last_toggle_q <= 1'b0;
         pair_q        <= '0;
         commit_q      <= 1'b0;
         odd_q         <= '0;
         cmd_count_q   <= '0;
         overrun_q     <= 1'b0;
         addr_err_q    <= 1'b0;
         timeout_q     <= 1'b0;
         active_bank_q <= 1'b0;
         bank_swap_q   <= 1'b0;
         coef_we_q     <= 1'b0;
         coef_addr_q   <= '0;
         coef_wdata_q  <= '0;
      end else begin
         data_q <= coef_data_reg;
         ctrl_q <= coef_ctrl_reg;
         sync_q <= sync_in;

         coef_we_q    <= 1'b0;
         coef_addr_q  <= '0;
         coef_wdata_q <= '0;
         bank_swap_q  <= 1'b0;

         // A toggle seen while busy is not queued; IDLE re-compares the final level.
         if ((state_q != IDLE) && new_cmd) begin
            overrun_q <= 1'b1;
         end

         // Write strobes are launched one state early so they are registered in WR_EVEN/WR_ODD.
         case (state_q)
            IDLE: begin
               if (new_cmd) begin
                  last_toggle_q <= ctrl_q[TOGGLE_BIT];
                  cmd_count_q   <= cmd_count_q + 16'd1;
                  pair_q        <= new_pair;
                  commit_q      <= ctrl_q[COMMIT_BIT];
                  odd_q         <= data_q[15:0];
                  if (pair_bad) begin
                     addr_err_q <= 1'b1;
                  end else begin
                     state_q      <= WR_EVEN;
                     coef_we_q    <= 1'b1;
                     coef_addr_q  <= ADDR_W'({new_pair, 1'b0});
                     coef_wdata_q <= data_q[31:16];
                  end
               end
            end
            WR_EVEN: begin
               state_q      <= WR_ODD;
               coef_we_q    <= 1'b1;
               coef_addr_q  <= ADDR_W'({pair_q, 1'b1});
               coef_wdata_q <= odd_q;
            end
            WR_ODD: begin
               state_q <= commit_q ? WAIT_SYNC : IDLE;
            end
            WAIT_SYNC: begin
               if (sync_q) begin
                  bank_swap_q   <= 1'b1;
                  active_bank_q <= ~active_bank_q;
                  state_q       <= IDLE;
               end else if (tmr_expired) begin
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign coef_we     = coef_we_q;
   assign coef_addr   = coef_addr_q;
   assign coef_wdata  = coef_wdata_q;
   assign bank_swap   = bank_swap_q;
   assign active_bank = active_bank_q;
   assign busy        = state_q != IDLE;

   always_comb begin
      status                              = '0;
      status[ST_BUSY]                     = busy;
      status[ST_OVERRUN]                  = overrun_q;
      status[ST_ADDR_ERR]                 = addr_err_q;
      status[ST_TIMEOUT]                  = timeout_q;
      status[ST_BANK]                     = active_bank_q;
      status[ST_CNT_LSB +: ST_CNT_W]      = cmd_count_q;
   end

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Bench for fir_coeff_load_ctrl: directed scenarios then random traffic, every cycle
// checked against an event-scheduling reference model (pending writes, busy-until time, wait window).
module tb_fir_coeff_load_ctrl;

   localparam int T      = 64;
   localparam int NPAIRS = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dreg;
   logic [31:0] creg;
   logic        sync;
   logic        coef_we;
   logic [4:0]  coef_addr;
   logic [15:0] coef_wdata;
   logic        bank_swap;
   logic        active_bank;
   logic        busy;
   logic [31:0] status;

   always #5 clk = ~clk;

   fir_coeff_load_ctrl #(
      .NPAIRS       (NPAIRS),
      .COEF_W       (16),
      .ADDR_W       (5),
      .SYNC_TIMEOUT (T)
   ) dut (
      .OPB_Clk       (clk),
      .OPB_Rst       (rst),
      .coef_data_reg (dreg),
      .coef_ctrl_reg (creg),
      .sync_in       (sync),
      .coef_we       (coef_we),
      .coef_addr     (coef_addr),
      .coef_wdata    (coef_wdata),
      .bank_swap     (bank_swap),
      .active_bank   (active_bank),
      .busy          (busy),
      .status        (status)
   );

   int     checks = 0;
   int     errors = 0;
   longint cyc    = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      longint      at;
      logic [4:0]  addr;
      logic [15:0] wd;
   } wr_t;

   wr_t         wq[$];
   bit          m_tog_q, m_com_q, m_sync_q;
   logic [7:0]  m_p_q;
   logic [31:0] m_data_q;
   bit          m_last, m_bank, m_ovr, m_aerr, m_to, waiting, e_swap;
   logic [15:0] m_cnt;
   longint      free_at   = 0;
   longint      wait_from = 0;
   bit          e_we;
   logic [4:0]  e_addr;
   logic [15:0] e_wd;

   task automatic model_reset();
      wq.delete();
      m_tog_q = 0; m_com_q = 0; m_sync_q = 0; m_p_q = '0; m_data_q = '0;
      m_last = 0; m_bank = 0; m_ovr = 0; m_aerr = 0; m_to = 0; waiting = 0; e_swap = 0;
      m_cnt = '0; free_at = 0; wait_from = 0;
   endtask

   // Evaluate cycle c with the registered inputs; results become visible in cycle c+1.
   task automatic model_step(input longint c);
      bit idle;
      wr_t w;
      idle   = (c >= free_at);
      e_swap = 0;
      if (waiting && c >= wait_from) begin
         if (m_sync_q) begin
            e_swap = 1; m_bank = !m_bank; waiting = 0; free_at = c + 1;
         end else if (c == wait_from + T - 1) begin
            m_to = 1; waiting = 0; free_at = c + 1;
         end
      end
      if (m_tog_q != m_last) begin
         if (idle) begin
            m_last = m_tog_q;
            m_cnt  = m_cnt + 16'd1;
            if (int'(m_p_q) >= NPAIRS) begin
               m_aerr = 1;
            end else begin
               w.at = c + 1; w.addr = 5'(2 * int'(m_p_q));     w.wd = m_data_q[31:16]; wq.push_back(w);
               w.at = c + 2; w.addr = 5'(2 * int'(m_p_q) + 1); w.wd = m_data_q[15:0];  wq.push_back(w);
               if (m_com_q) begin
                  waiting = 1; wait_from = c + 3; free_at = 64'h7fff_ffff_ffff_ffff;
               end else begin
                  free_at = c + 3;
               end
            end
         end else begin
            m_ovr = 1;
         end
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         model_reset();
      end else begin
         model_step(cyc);
         m_tog_q  = creg[31];
         m_com_q  = creg[30];
         m_p_q    = creg[7:0];
         m_data_q = dreg;
         m_sync_q = sync;
      end
      cyc++;
      e_we = 0; e_addr = '0; e_wd = '0;
      if (wq.size() > 0 && wq[0].at == cyc) begin
         e_we = 1; e_addr = wq[0].addr; e_wd = wq[0].wd;
         void'(wq.pop_front());
      end
      #1;
      chk("coef_we",     {31'd0, coef_we},     {31'd0, e_we});
      chk("coef_addr",   {27'd0, coef_addr},   {27'd0, e_addr});
      chk("coef_wdata",  {16'd0, coef_wdata},  {16'd0, e_wd});
      chk("bank_swap",   {31'd0, bank_swap},   {31'd0, e_swap});
      chk("active_bank", {31'd0, active_bank}, {31'd0, m_bank});
      chk("busy",        {31'd0, busy},        {31'd0, cyc < free_at});
      chk("status", status, {(cyc < free_at), m_ovr, m_aerr, m_to, m_bank, 11'd0, m_cnt});
   end

   // ---------------- stimulus ----------------
   bit tog = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] p, input bit commit, input logic [31:0] data);
      tog  = !tog;
      creg = {tog, commit, 22'd0, p};
      dreg = data;
   endtask

   initial begin
      int sync_pct;
      rst = 1'b1; dreg = '0; creg = '0; sync = 1'b0;
      tick(3);
      chk("reset_status", status, 32'd0);
      rst = 1'b0;
      tick(3);

      // plain write pair, no commit
      send(8'd12, 1'b0, 32'h1234_ABCD);
      tick(6);
      chk("tp1_count", {16'd0, status[15:0]}, 32'd1);

      // commit, sync 10 cycles after WR_ODD
      send(8'd12, 1'b1, 32'h1234_ABCD);
      tick(13);
      sync = 1'b1;
      tick(1);
      sync = 1'b0;
      tick(5);
      chk("tp2_bank", {31'd0, active_bank}, 32'd1);
      chk("tp2_status27", {31'd0, status[27]}, 32'd1);

      // out-of-range pair index
      send(8'd16, 1'b0, 32'hDEAD_BEEF);
      tick(5);
      chk("tp3_addr_err", {31'd0, status[29]}, 32'd1);
      chk("tp3_count", {16'd0, status[15:0]}, 32'd3);

      // commit with no sync -> timeout
      send(8'd3, 1'b1, 32'h0102_0304);
      tick(T + 8);
      chk("tp4_timeout", {31'd0, status[28]}, 32'd1);
      chk("tp4_bank", {31'd0, active_bank}, 32'd1);
      chk("tp4_busy", {31'd0, busy}, 32'd0);

      // toggle flip landing in WR_EVEN -> overrun, one extra pair
      send(8'd5, 1'b0, 32'h1111_2222);
      tick(1);
      send(8'd7, 1'b0, 32'h5555_AAAA);
      tick(8);
      chk("tp5_overrun", {31'd0, status[30]}, 32'd1);

      // reset while waiting for sync
      send(8'd1, 1'b1, 32'hCAFE_F00D);
      tick(6);
      rst = 1'b1; creg = '0; tog = 0;
      tick(1);
      rst = 1'b0;
      repeat (3) begin
         sync = 1'b1; tick(1); sync = 1'b0; tick(4);
      end
      chk("tp6_status", status, 32'd0);
      chk("tp6_bank", {31'd0, active_bank}, 32'd0);

      // random traffic
      sync_pct = 5;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) sync_pct = ($urandom_range(0, 1) == 0) ? 0 : 5;
         if ($urandom_range(0, 7) == 0)
            send(8'($urandom_range(0, 17)), 1'($urandom_range(0, 1)), $urandom);
         sync = ($urandom_range(0, 99) < sync_pct);
         rst  = ($urandom_range(0, 599) == 0);
         tick(1);
      end
      rst = 1'b0; sync = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
